// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and defaults for the instruction-fetch sequencer.
//   fetch_state_t : sequencer state (IDLE, RUN, HALT)
//   A_DEF, W_DEF  : default address / instruction widths
//   HALT_OP_DEF   : default instruction encoding that stops fetch
package fetch_pkg;

   localparam int         A_DEF       = 8;
   localparam int         W_DEF       = 9;
   localparam logic [8:0] HALT_OP_DEF = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// pc_next
// Combinational next-PC calculation for the fetch sequencer.
//   pc            in  : current program counter
//   instr_pc      in  : address of the instruction being executed
//   branch_en     in  : execute requests a redirect
//   branch_rel    in  : 1 = PC-relative, 0 = absolute target
//   branch_target in  : absolute address or two's-complement offset
//   instr_valid   in  : instr_pc belongs to a live instruction
//   take_branch   out : redirect is honoured this cycle
//   next_pc       out : branch target when taken, otherwise pc+1
// All arithmetic is modulo 2^A; nothing flags overflow or wrap.
module pc_next #(
   parameter int A = 8
) (
   input  logic [A-1:0] pc,
   input  logic [A-1:0] instr_pc,
   input  logic         branch_en,
   input  logic         branch_rel,
   input  logic [A-1:0] branch_target,
   input  logic         instr_valid,
   output logic         take_branch,
   output logic [A-1:0] next_pc
);

   logic [A:0]   rel_sum_s;
   logic [A-1:0] target_s;

   // Select branch target or sequential successor; A-bit truncation gives the wrap.
   always_comb begin
      take_branch = branch_en & instr_valid;
      // Sign-extend the offset one bit so the sum is an explicit signed add,
      // then keep the low A bits: wraps in both directions.
      rel_sum_s = {instr_pc[A-1], instr_pc} + {branch_target[A-1], branch_target};
      if (branch_rel) begin
         target_s = rel_sum_s[A-1:0];
      end else begin
         target_s = branch_target;
      end
      if (take_branch) begin
         next_pc = target_s;
      end else begin
         next_pc = pc + {{(A-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction ROM and registers the returned word for decode/execute.
//   clk, reset     : clock, synchronous active-high reset
//   start          : pulse; begin (or restart) execution at address 0
//   stall          : downstream not ready; freeze all fetch state
//   branch_en/rel/target : redirect request belonging to instr_out
//   rom_addr       : ROM address, always equal to the PC
//   rom_data       : ROM word at rom_addr (same cycle)
//   instr_out/instr_pc/instr_valid : fetched instruction register
//   done           : HALT_OP was fetched; program finished
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int         A       = A_DEF,
   parameter int         W       = W_DEF,
   parameter logic [W-1:0] HALT_OP = W'(HALT_OP_DEF)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stall,
   input  logic         branch_en,
   input  logic         branch_rel,
   input  logic [A-1:0] branch_target,
   output logic [A-1:0] rom_addr,
   input  logic [W-1:0] rom_data,
   output logic [W-1:0] instr_out,
   output logic [A-1:0] instr_pc,
   output logic         instr_valid,
   output logic         done
);

   fetch_state_t state_r;
   logic [A-1:0] pc_r;
   logic [A-1:0] next_pc_s;
   logic         take_branch_s;

   assign rom_addr = pc_r;

   pc_next #(.A(A)) u_pc_next (
      .pc            (pc_r),
      .instr_pc      (instr_pc),
      .branch_en     (branch_en),
      .branch_rel    (branch_rel),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .take_branch   (take_branch_s),
      .next_pc       (next_pc_s)
   );

   // Sequencer FSM with the PC and the registered fetch outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         pc_r        <= {A{1'b0}};
         instr_out   <= {W{1'b0}};
         instr_pc    <= {A{1'b0}};
         instr_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               pc_r        <= {A{1'b0}};
               instr_valid <= 1'b0;
               done        <= 1'b0;
               if (start) begin
                  state_r <= RUN;
               end
            end
            RUN: begin
               // Stall freezes everything, including branch and halt evaluation.
               if (!stall) begin
                  if (take_branch_s) begin
                     // Word on rom_data is squashed, so a halt word here is ignored.
                     pc_r        <= next_pc_s;
                     instr_valid <= 1'b0;
                  end else if (rom_data == HALT_OP) begin
                     // PC stays on the halt word; the halt word is never issued.
                     state_r     <= HALT;
                     instr_valid <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     instr_out   <= rom_data;
                     instr_pc    <= pc_r;
                     instr_valid <= 1'b1;
                     pc_r        <= next_pc_s;
                  end
               end
            end
            HALT: begin
               instr_valid <= 1'b0;
               if (start) begin
                  state_r <= RUN;
                  pc_r    <= {A{1'b0}};
                  done    <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               pc_r        <= {A{1'b0}};
               instr_valid <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the combinational instruction ROM.
- Presents ROM address from the PC and registers the returned word into a one-entry fetch register for decode/execute.
- Handles start/halt, downstream stall, and absolute or PC-relative branches.
- Sits between instruction ROM and the decoder in the lab processor top level.

Parameters:
A, 8, PC / ROM address width
W, 9, instruction width
HALT_OP, 9'h1FF, instruction encoding that stops fetch (width W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin execution at address 0
stall  in  1  downstream not ready; freeze fetch state
branch_en  in  1  redirect PC (from execute of instr_out)
branch_rel  in  1  1: target = instr_pc + signed offset; 0: absolute
branch_target  in  A  absolute address or two's-complement offset
rom_addr  out  A  to ROM instAddress; equals PC
rom_data  in  W  from ROM instrOut (same-cycle, combinational)
instr_out  out  W  fetched instruction register
instr_pc  out  A  address of instr_out
instr_valid  out  1  instr_out holds a live instruction
done  out  1  HALT_OP fetched; program finished

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset, sampled on clk rising edge: state=IDLE, PC=0, instr_out=0, instr_pc=0, instr_valid=0, done=0. Reset mid-program aborts with no residue.
- rom_addr = PC at all times, purely combinational. Fetch latency: ROM word at PC appears on instr_out one cycle later.
- States: IDLE, RUN, HALT.
- IDLE: PC held 0, instr_valid=0. start=1 -> RUN with PC=0.
- RUN, stall=0, branch_en=0:
  - instr_out<=rom_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
- RUN, stall=0, branch_en=1 (branch belongs to instr_out):
  - PC<=target, where target = branch_rel ? instr_pc+$signed(branch_target) : branch_target.
  - The word currently on rom_data is squashed: instr_valid<=0, instr_out holds its old value.
  - Next cycle fetches from target.
- branch_en while instr_valid=0 is ignored.
- RUN, stall=1: PC, instr_out, instr_pc, instr_valid all hold. branch_en and halt detection are not evaluated; downstream must keep branch_en asserted until stall drops.
- Halt: in RUN, stall=0, no branch taken, rom_data==HALT_OP -> HALT.
  - On that edge: instr_valid<=0, done<=1, PC holds (points at the halt word).
  - HALT_OP itself is never issued as valid.
- A branch taken on the same edge wins over halt detection, because the halt word is squashed.
- HALT: done=1, instr_valid=0, PC frozen. start=1 -> RUN with PC=0 and done<=0 (restart).
- start is ignored in RUN.
- Arithmetic: all PC math is modulo 2^A. PC+1 from 2^A-1 wraps to 0. Relative targets wrap both directions, with no error flag.
- Running off the end of the ROM without HALT_OP simply wraps to address 0.

Decomposition:
- Package fetch_pkg: typedef enum logic[1:0] {IDLE, RUN, HALT} fetch_state_t; default HALT_OP localparam.
- One combinational sub-module, pc_next, computes next PC from (PC, instr_pc, branch_en, branch_rel, branch_target, instr_valid). It isolates the wrap and sign-extend arithmetic and can be unit-tested on its own.
- FSM and registers stay in fetch_ctrl.

Test Plan:
- ROM = {0:9'h001, 1:9'h002, 2:9'h003, 3:HALT_OP}; reset, then start pulse -> instr_out 001/002/003 with instr_pc 0/1/2 on three consecutive cycles; then instr_valid=0, done=1, rom_addr stays 3.
- Stall=1 for 2 cycles while instr_out=002 -> instr_out, instr_pc=1 and rom_addr=2 are frozen; fetch resumes with 003 one cycle after stall drops.
- Absolute branch: branch_en=1, branch_rel=0, target=8'h40 while instr_pc=1 -> next cycle instr_valid=0; following cycle instr_pc=8'h40, instr_out=ROM[0x40].
- Relative branch with wrap: instr_pc=8'h02, branch_rel=1, target=8'hFC (-4) -> fetch resumes at 8'hFE. Also PC 8'hFF increments to 8'h00 with no HALT in ROM.
- Edge conditions:
  - Branch taken on the edge where rom_data==HALT_OP -> no halt; done stays 0.
  - reset asserted mid-RUN -> next edge all outputs 0, state IDLE.
  - start in HALT -> done clears and instr_pc=0 is reissued.
